demux_saidas: RTL and testbench

DEMUX_SAIDAS -- requirements
Module: demux_saidas

---
 rtl/demux_saidas_pkg.sv | 26 ++
 rtl/demux_saidas_contador_rr.sv | 32 +++
 rtl/demux_saidas.sv | 109 ++++++++++
 tb/tb_demux_saidas.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/demux_saidas_pkg.sv
// Shared constants for the demux_saidas block: slot selector codes,
// default data width and the slot decoder used by the top level.
package demux_saidas_pkg;

   localparam int LARGURA_PADRAO = 16;
   localparam int NUM_SAIDAS     = 4;

   localparam logic [1:0] SEL_SAIDA0 = 2'b00;
   localparam logic [1:0] SEL_SAIDA1 = 2'b01;
   localparam logic [1:0] SEL_SAIDA2 = 2'b10;
   localparam logic [1:0] SEL_SAIDA3 = 2'b11;

   // One-hot mask of the slot addressed by a selector code
   function automatic logic [NUM_SAIDAS-1:0] decodifica(input logic [1:0] sel);
      logic [NUM_SAIDAS-1:0] mascara;
      case (sel)
         SEL_SAIDA0: mascara = 4'b0001;
         SEL_SAIDA1: mascara = 4'b0010;
         SEL_SAIDA2: mascara = 4'b0100;
         SEL_SAIDA3: mascara = 4'b1000;
         default:    mascara = 4'b0000;
      endcase
      return mascara;
   endfunction

endpackage

// File: rtl/demux_saidas_contador_rr.sv
// contador_rr: 2-bit round-robin pointer. Advances by one when habilita is
// high, wraps 3 -> 0, synchronous active-low reset.
module contador_rr (
   input  logic       clock,
   input  logic       reset,
   input  logic       habilita,
   output logic [1:0] valor
);

   logic [1:0] valor_q;
   logic [1:0] valor_d;

   // Next pointer value: natural 2-bit wrap on increment
   always_comb begin
      valor_d = valor_q;
      if (habilita) begin
         valor_d = valor_q + 2'd1;
      end
   end

   // Pointer register
   always_ff @(posedge clock) begin
      if (!reset) begin
         valor_q <= 2'd0;
      end else begin
         valor_q <= valor_d;
      end
   end

   assign valor = valor_q;

endmodule

// File: rtl/demux_saidas.sv
// demux_saidas: distributes a data word to one of four holding slots, chosen
// manually (controle) or round-robin (internal pointer). Each slot carries a
// valid bit cleared by limpa; a write onto a still-valid slot pulses
// sobrescrita.
// Build option: define DEMUX_SAIDAS_PROTEGE_EN to drop writes that would
// overwrite a valid slot (pointer does not advance); undefined, such writes
// overwrite the slot.
module demux_saidas
   import demux_saidas_pkg::*;
#(
   parameter int LARGURA = LARGURA_PADRAO
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] entrada,
   input  logic               escreve,
   input  logic [1:0]         controle,
   input  logic               auto,
   input  logic [3:0]         limpa,
   output logic [LARGURA-1:0] saida0,
   output logic [LARGURA-1:0] saida1,
   output logic [LARGURA-1:0] saida2,
   output logic [LARGURA-1:0] saida3,
   output logic [3:0]         valido,
   output logic               sobrescrita,
   output logic [1:0]         ponteiro
);

   logic [LARGURA-1:0]    saida_q [NUM_SAIDAS];
   logic [LARGURA-1:0]    saida_d [NUM_SAIDAS];
   logic [NUM_SAIDAS-1:0] valido_q;
   logic [NUM_SAIDAS-1:0] valido_d;
   logic                  sobrescrita_q;
   logic                  sobrescrita_d;

   logic [1:0]            ponteiro_w;
   logic [1:0]            destino;
   logic [NUM_SAIDAS-1:0] alvo;
   logic                  ocupado;
   logic                  grava;
   logic                  avanca;

   // Round-robin pointer; only advances on writes that actually land in auto mode
   contador_rr u_contador_rr (
      .clock    (clock),
      .reset    (reset),
      .habilita (avanca),
      .valor    (ponteiro_w)
   );

   // Destination decode, conflict detection and valid-bit next state
   always_comb begin
      destino       = auto ? ponteiro_w : controle;
      alvo          = decodifica(destino);
      // A slot being cleared this same cycle is free to take the write
      ocupado       = |(alvo & valido_q & ~limpa);
`ifdef DEMUX_SAIDAS_PROTEGE_EN
      grava         = escreve & ~ocupado;
`else
      grava         = escreve;
`endif
      avanca        = grava & auto;
      sobrescrita_d = escreve & ocupado;
      valido_d      = valido_q & ~limpa;
      if (grava) begin
         valido_d = valido_d | alvo;
      end
   end

   // Status registers
   always_ff @(posedge clock) begin
      if (!reset) begin
         valido_q      <= '0;
         sobrescrita_q <= 1'b0;
      end else begin
         valido_q      <= valido_d;
         sobrescrita_q <= sobrescrita_d;
      end
   end

   // Per-slot data holding registers; only the addressed slot loads
   for (genvar gi = 0; gi < NUM_SAIDAS; gi++) begin : g_slot
      // Slot next value: load on an accepted write to this slot, else hold
      always_comb begin
         saida_d[gi] = saida_q[gi];
         if (grava && alvo[gi]) begin
            saida_d[gi] = entrada;
         end
      end

      // Slot data register
      always_ff @(posedge clock) begin
         if (!reset) begin
            saida_q[gi] <= '0;
         end else begin
            saida_q[gi] <= saida_d[gi];
         end
      end
   end

   assign saida0      = saida_q[0];
   assign saida1      = saida_q[1];
   assign saida2      = saida_q[2];
   assign saida3      = saida_q[3];
   assign valido      = valido_q;
   assign sobrescrita = sobrescrita_q;
   assign ponteiro    = ponteiro_w;

endmodule

// File: tb/tb_demux_saidas.sv
// Self-checking bench for demux_saidas: directed scenarios plus randomized
// traffic compared against a behavioural slot model.
// Honours DEMUX_SAIDAS_PROTEGE_EN in its reference model.
module tb_demux_saidas;

   logic        clock;
   logic        reset;
   logic [15:0] entrada;
   logic        escreve;
   logic [1:0]  controle;
   logic        auto;
   logic [3:0]  limpa;
   logic [15:0] saida0, saida1, saida2, saida3;
   logic [3:0]  valido;
   logic        sobrescrita;
   logic [1:0]  ponteiro;

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [15:0] m_saida [4];
   logic [3:0]  m_valido;
   logic [1:0]  m_ptr;
   logic        m_sobre;

`ifdef DEMUX_SAIDAS_PROTEGE_EN
   localparam bit PROTEGE = 1'b1;
`else
   localparam bit PROTEGE = 1'b0;
`endif

   demux_saidas #(.LARGURA(16)) dut (
      .clock       (clock),
      .reset       (reset),
      .entrada     (entrada),
      .escreve     (escreve),
      .controle    (controle),
      .auto        (auto),
      .limpa       (limpa),
      .saida0      (saida0),
      .saida1      (saida1),
      .saida2      (saida2),
      .saida3      (saida3),
      .valido      (valido),
      .sobrescrita (sobrescrita),
      .ponteiro    (ponteiro)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] saida_dut(input int i);
      case (i)
         0: return saida0;
         1: return saida1;
         2: return saida2;
         default: return saida3;
      endcase
   endfunction

   // Advance one clock edge, update the model from the sampled inputs,
   // then settle 1 time unit past the edge.
   task automatic passo();
      int          d;
      bit          busy;
      logic [3:0]  novo_valido;
      @(posedge clock);
      if (!reset) begin
         for (int i = 0; i < 4; i++) m_saida[i] = 16'h0000;
         m_valido = 4'b0000;
         m_ptr    = 2'd0;
         m_sobre  = 1'b0;
      end else begin
         novo_valido = m_valido;
         for (int i = 0; i < 4; i++) if (limpa[i]) novo_valido[i] = 1'b0;
         m_sobre = 1'b0;
         if (escreve) begin
            d = auto ? int'(m_ptr) : int'(controle);
            busy = m_valido[d] && !limpa[d];
            m_sobre = busy;
            if (!(PROTEGE && busy)) begin
               m_saida[d]     = entrada;
               novo_valido[d] = 1'b1;
               if (auto) m_ptr = 2'((int'(m_ptr) + 1) % 4);
            end
         end
         m_valido = novo_valido;
      end
      #1;
      $display("t=%0t rst=%b wr=%b auto=%b ctl=%0d in=%h limpa=%b -> val=%b ptr=%0d sob=%b",
               $time, reset, escreve, auto, controle, entrada, limpa, valido, ponteiro, sobrescrita);
   endtask

   task automatic ocioso();
      reset   = 1'b1;
      escreve = 1'b0;
      limpa   = 4'b0000;
   endtask

   task automatic aplica_reset();
      reset   = 1'b0;
      escreve = 1'b0;
      limpa   = 4'b0000;
      passo();
      ocioso();
   endtask

   task automatic test_reset();
      reset    = 1'b0;
      escreve  = 1'b1;
      auto     = 1'b0;
      controle = 2'd1;
      entrada  = 16'h1234;
      limpa    = 4'b0000;
      passo();
      ocioso();
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (saida_dut(i) !== 16'h0000) begin
            errors++;
            $display("FAIL reset_saida%0d got %h expected 0000", i, saida_dut(i));
         end
      end
      checks++;
      if (valido !== 4'b0000) begin
         errors++; $display("FAIL reset_valido got %b expected 0000", valido);
      end
      checks++;
      if (ponteiro !== 2'd0) begin
         errors++; $display("FAIL reset_ponteiro got %0d expected 0", ponteiro);
      end
      checks++;
      if (sobrescrita !== 1'b0) begin
         errors++; $display("FAIL reset_sobrescrita got %b expected 0", sobrescrita);
      end
   endtask

   task automatic test_manual();
      aplica_reset();
      auto     = 1'b0;
      controle = 2'b10;
      entrada  = 16'hBEEF;
      escreve  = 1'b1;
      passo();
      ocioso();
      checks++;
      if (saida2 !== 16'hBEEF) begin
         errors++; $display("FAIL manual_saida2 got %h expected BEEF", saida2);
      end
      checks++;
      if (valido !== 4'b0100) begin
         errors++; $display("FAIL manual_valido got %b expected 0100", valido);
      end
      checks++;
      if ({saida0, saida1, saida3} !== 48'h0) begin
         errors++; $display("FAIL manual_outros got %h/%h/%h expected 0", saida0, saida1, saida3);
      end
   endtask

   task automatic test_auto_round();
      logic [1:0] exp_ptr;
      int         pulsos;
      aplica_reset();
      pulsos = 0;
      auto   = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         exp_ptr = 2'((k - 1) % 4);
         checks++;
         if (ponteiro !== exp_ptr) begin
            errors++; $display("FAIL auto_ponteiro_w%0d got %0d expected %0d", k, ponteiro, exp_ptr);
         end
         entrada = 16'(k);
         escreve = 1'b1;
         passo();
         if (sobrescrita) pulsos++;
         checks++;
         if (sobrescrita !== (k == 5)) begin
            errors++; $display("FAIL auto_sob_w%0d got %b expected %b", k, sobrescrita, (k == 5));
         end
      end
      ocioso();
      exp_ptr = PROTEGE ? 2'd0 : 2'd1;
      checks++;
      if (ponteiro !== exp_ptr) begin
         errors++; $display("FAIL auto_ponteiro_final got %0d expected %0d", ponteiro, exp_ptr);
      end
      checks++;
      if (saida0 !== (PROTEGE ? 16'h0001 : 16'h0005)) begin
         errors++; $display("FAIL auto_saida0 got %h expected %h", saida0, (PROTEGE ? 16'h0001 : 16'h0005));
      end
      checks++;
      if ({saida1, saida2, saida3} !== {16'h0002, 16'h0003, 16'h0004}) begin
         errors++; $display("FAIL auto_saida123 got %h/%h/%h expected 0002/0003/0004", saida1, saida2, saida3);
      end
      passo();
      if (sobrescrita) pulsos++;
      checks++;
      if (pulsos !== 1) begin
         errors++; $display("FAIL auto_pulsos got %0d expected 1", pulsos);
      end
   endtask

   task automatic test_write_limpa();
      aplica_reset();
      auto     = 1'b0;
      controle = 2'b00;
      entrada  = 16'h0011;
      escreve  = 1'b1;
      passo();
      entrada  = 16'h00AA;
      limpa    = 4'b0001;
      passo();
      ocioso();
      checks++;
      if (saida0 !== 16'h00AA) begin
         errors++; $display("FAIL wl_saida0 got %h expected 00AA", saida0);
      end
      checks++;
      if (valido[0] !== 1'b1) begin
         errors++; $display("FAIL wl_valido0 got %b expected 1", valido[0]);
      end
      checks++;
      if (sobrescrita !== 1'b0) begin
         errors++; $display("FAIL wl_sobrescrita got %b expected 0", sobrescrita);
      end
   endtask

   task automatic test_reset_priority();
      aplica_reset();
      auto = 1'b0; escreve = 1'b1;
      controle = 2'd1; entrada = 16'h1111; passo();
      controle = 2'd3; entrada = 16'h3333; passo();
      auto = 1'b1; controle = 2'd0; entrada = 16'h2222; passo();
      // pointer is now 1, slots 0,1,3 valid; reset together with a write
      reset = 1'b0; escreve = 1'b1; limpa = 4'b0010; entrada = 16'h7777;
      passo();
      ocioso();
      checks++;
      if ({saida0, saida1, saida2, saida3} !== 64'h0) begin
         errors++; $display("FAIL rp_saidas got %h/%h/%h/%h expected 0", saida0, saida1, saida2, saida3);
      end
      checks++;
      if ({valido, ponteiro, sobrescrita} !== 7'b0) begin
         errors++; $display("FAIL rp_status got val=%b ptr=%0d sob=%b expected 0", valido, ponteiro, sobrescrita);
      end
   endtask

   task automatic test_limpa_all();
      aplica_reset();
      auto = 1'b0; escreve = 1'b1;
      controle = 2'd1; entrada = 16'hA1A1; passo();
      controle = 2'd3; entrada = 16'hC3C3; passo();
      escreve = 1'b0; limpa = 4'b1111; passo();
      ocioso();
      checks++;
      if (valido !== 4'b0000) begin
         errors++; $display("FAIL la_valido got %b expected 0000", valido);
      end
      checks++;
      if ({saida0, saida1, saida2, saida3} !== {16'h0000, 16'hA1A1, 16'h0000, 16'hC3C3}) begin
         errors++; $display("FAIL la_saidas got %h/%h/%h/%h expected 0000/A1A1/0000/C3C3", saida0, saida1, saida2, saida3);
      end
   endtask

   task automatic test_random();
      aplica_reset();
      for (int n = 0; n < 300; n++) begin
         reset    = ($urandom_range(0, 39) != 0);
         escreve  = ($urandom_range(0, 3) != 0);
         auto     = ($urandom_range(0, 1) != 0);
         controle = 2'($urandom_range(0, 3));
         entrada  = 16'($urandom);
         limpa    = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
         passo();
         for (int i = 0; i < 4; i++) begin
            checks++;
            if (saida_dut(i) !== m_saida[i]) begin
               errors++; $display("FAIL rnd_saida%0d cycle %0d got %h expected %h", i, n, saida_dut(i), m_saida[i]);
            end
         end
         checks++;
         if (valido !== m_valido) begin
            errors++; $display("FAIL rnd_valido cycle %0d got %b expected %b", n, valido, m_valido);
         end
         checks++;
         if (ponteiro !== m_ptr) begin
            errors++; $display("FAIL rnd_ponteiro cycle %0d got %0d expected %0d", n, ponteiro, m_ptr);
         end
         checks++;
         if (sobrescrita !== m_sobre) begin
            errors++; $display("FAIL rnd_sobrescrita cycle %0d got %b expected %b", n, sobrescrita, m_sobre);
         end
      end
      ocioso();
   endtask

   initial begin
      reset    = 1'b0;
      entrada  = 16'h0000;
      escreve  = 1'b0;
      controle = 2'd0;
      auto     = 1'b0;
      limpa    = 4'b0000;
      for (int i = 0; i < 4; i++) m_saida[i] = 16'h0000;
      m_valido = 4'b0000;
      m_ptr    = 2'd0;
      m_sobre  = 1'b0;
      #2;
      test_reset();
      test_manual();
      test_auto_round();
      test_write_limpa();
      test_reset_priority();
      test_limpa_all();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
